// File: rtl/histogram_bins.sv
// histogram_bins: 256-bin intensity histogram with in-order drain.
// Each 8-bit In1 token is a bin index. The block adds one to that bin's
// counter in a dual-port RAM. After FRAME_PIXELS tokens it sends bins 0..255
// on Out1 and zeroes each bin as it is sent.
// Ports:
//   CLK, RESET      clock; synchronous active-low reset
//   In1_DATA/SEND   pixel token in; In1_COUNT is ignored
//   In1_ACK         token consumed this cycle (ACCUM only)
//   Out1_DATA/SEND  bin count out; SEND = data valid & Out1_RDY
//   Out1_RDY        downstream ready; Out1_ACK is ignored
//   Out1_COUNT      constant 1
module histogram_bins #(
  parameter int unsigned FRAME_PIXELS = 262144,
  parameter int unsigned COUNT_W      = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         In1_DATA,
  input  logic               In1_SEND,
  input  logic [15:0]        In1_COUNT,
  output logic               In1_ACK,
  output logic [COUNT_W-1:0] Out1_DATA,
  output logic               Out1_SEND,
  input  logic               Out1_RDY,
  input  logic               Out1_ACK,
  output logic [15:0]        Out1_COUNT
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BINS   = 256;

  typedef enum logic [1:0] {ST_CLEAR, ST_ACCUM, ST_FLUSH, ST_DRAIN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic                flush_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                dvld_q;
  logic                s1_vld_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic                s2_vld_q;
  logic [ADDR_W-1:0]   s2_addr_q;
  logic [COUNT_W-1:0]  s2_data_q;
  logic [COUNT_W-1:0]  rd_q;
  logic [COUNT_W-1:0]  mem_q [BINS];

  logic                we_c;
  logic [ADDR_W-1:0]   waddr_c;
  logic [COUNT_W-1:0]  wdata_c;
  logic                re_c;
  logic [ADDR_W-1:0]   raddr_c;
  logic                fwd_c;
  logic [COUNT_W-1:0]  acc_d;

  logic unused_inputs;
  assign unused_inputs = ^{In1_COUNT, Out1_ACK};

  assign In1_ACK    = (state_q == ST_ACCUM) & In1_SEND;
  assign Out1_SEND  = (state_q == ST_DRAIN) & dvld_q & Out1_RDY;
  assign Out1_DATA  = rd_q;
  assign Out1_COUNT = 16'h1;

  // The RAM read returns the old value when the previous pixel's write lands
  // on the same edge, so a same-bin pixel one cycle behind takes the stage-2 result.
  assign fwd_c = s2_vld_q && (s2_addr_q == s1_addr_q);
  assign acc_d = (fwd_c ? s2_data_q : rd_q) + COUNT_W'(1);

  // RAM port control: clear sweep, increment write-back, drain zeroing.
  always_comb begin
    we_c    = 1'b0;
    waddr_c = '0;
    wdata_c = '0;
    re_c    = 1'b0;
    raddr_c = '0;
    if (s1_vld_q) begin
      we_c    = 1'b1;
      waddr_c = s1_addr_q;
      wdata_c = acc_d;
    end
    case (state_q)
      ST_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = clr_q;
        wdata_c = '0;
      end
      ST_ACCUM: begin
        if (In1_ACK) begin
          re_c    = 1'b1;
          raddr_c = In1_DATA;
        end
      end
      ST_DRAIN: begin
        if (!dvld_q) begin
          re_c    = 1'b1;
          raddr_c = ptr_q;
        end else if (Out1_RDY) begin
          we_c    = 1'b1;
          waddr_c = ptr_q;
          wdata_c = '0;
          re_c    = 1'b1;
          raddr_c = ptr_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Bin storage.
  always_ff @(posedge CLK) begin
    if (we_c) mem_q[waddr_c] <= wdata_c;
  end

  // Control FSM, accumulate pipeline and read-data register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_CLEAR;
      clr_q     <= '0;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      ptr_q     <= '0;
      dvld_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_data_q <= '0;
      rd_q      <= '0;
    end else begin
      if (re_c) rd_q <= mem_q[raddr_c];

      s1_vld_q <= In1_ACK;
      if (In1_ACK) s1_addr_q <= In1_DATA;
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= acc_d;
      end

      case (state_q)
        ST_CLEAR: begin
          clr_q <= clr_q + 8'd1;
          if (clr_q == 8'd255) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (In1_ACK) begin
            if (cnt_q == COUNT_W'(FRAME_PIXELS - 1)) begin
              cnt_q   <= '0;
              flush_q <= 1'b0;
              state_q <= ST_FLUSH;
            end else begin
              cnt_q <= cnt_q + COUNT_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            flush_q <= 1'b0;
            dvld_q  <= 1'b0;
            ptr_q   <= '0;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!dvld_q) begin
            dvld_q <= 1'b1;
          end else if (Out1_RDY) begin
            if (ptr_q == 8'd255) begin
              ptr_q   <= '0;
              dvld_q  <= 1'b0;
              state_q <= ST_ACCUM;
            end else begin
              ptr_q <= ptr_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_bins.sv
// Self-checking bench for histogram_bins: directed frames with a histogram
// model kept as a plain array of counts, checked cycle by cycle.
module tb_histogram_bins;

  localparam int unsigned FP = 16;
  localparam int unsigned CW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [7:0]    In1_DATA;
  logic          In1_SEND;
  logic [15:0]   In1_COUNT;
  logic          In1_ACK;
  logic [CW-1:0] Out1_DATA;
  logic          Out1_SEND;
  logic          Out1_RDY;
  logic          Out1_ACK;
  logic [15:0]   Out1_COUNT;

  int vectors     = 0;
  int miscompares = 0;
  int unsigned model [256];
  logic [7:0] pix [$];

  histogram_bins #(.FRAME_PIXELS(FP), .COUNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
    .In1_ACK(In1_ACK),
    .Out1_DATA(Out1_DATA), .Out1_SEND(Out1_SEND), .Out1_RDY(Out1_RDY),
    .Out1_ACK(Out1_ACK), .Out1_COUNT(Out1_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are read 1 time unit later.
  task automatic cycle(input logic rst, input logic snd, input logic [7:0] d, input logic rdy);
    @(negedge CLK);
    RESET     = rst;
    In1_SEND  = snd;
    In1_DATA  = d;
    Out1_RDY  = rdy;
    In1_COUNT = 16'($urandom);
    Out1_ACK  = 1'($urandom);
    #1;
  endtask

  task automatic clear_model();
    for (int b = 0; b < 256; b++) model[b] = 0;
  endtask

  // Reset for two cycles, then expect 256 cycles of CLEAR with tokens pending.
  task automatic reset_seq();
    cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
    cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
    check("rst_ack", In1_ACK, 0);
    check("rst_send", Out1_SEND, 0);
    check("rst_data", Out1_DATA, 0);
    check("rst_count", Out1_COUNT, 16'h1);
    for (int c = 0; c < 256; c++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b1);
      check("clear_ack", In1_ACK, 0);
      check("clear_send", Out1_SEND, 0);
    end
    clear_model();
  endtask

  // Feed pix[] from ACCUM, check FLUSH and the drain against the model.
  // abort_at >= 0 stops the drain once that many bins have been sent.
  task automatic run_frame(input bit gaps, input bit rand_rdy, input int abort_at);
    int   i   = 0;
    int   cyc = 0;
    int   idx = 0;
    logic snd;
    logic rdy;
    while (i < pix.size() && cyc < 1000) begin
      snd = gaps ? ((cyc % 2) == 0) : 1'b1;
      cycle(1'b1, snd, snd ? pix[i] : 8'($urandom), 1'b1);
      check("accum_ack", In1_ACK, snd);
      check("accum_send", Out1_SEND, 0);
      if (snd) begin
        model[pix[i]]++;
        i++;
      end
      cyc++;
    end
    if (i < pix.size()) check("accum_timeout", i, pix.size());
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b1);
      check("flush_ack", In1_ACK, 0);
      check("flush_send", Out1_SEND, 0);
    end
    cyc = 0;
    while (idx < 256 && cyc < 4000) begin
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(1'b1, 1'b1, 8'($urandom), rdy);
      check("drain_ack", In1_ACK, 0);
      check("drain_send", Out1_SEND, rdy);
      check($sformatf("bin%0d", idx), Out1_DATA, model[idx]);
      if (rdy) begin
        model[idx] = 0;
        idx++;
      end
      cyc++;
      if (abort_at >= 0 && idx == abort_at) break;
    end
    if (abort_at < 0 && idx < 256) check("drain_timeout", idx, 256);
  endtask

  initial begin
    RESET = 1'b0; In1_SEND = 1'b0; In1_DATA = '0; In1_COUNT = '0;
    Out1_RDY = 1'b0; Out1_ACK = 1'b0;
    clear_model();
    reset_seq();

    // 16 sevens back-to-back.
    pix.delete();
    for (int k = 0; k < 16; k++) pix.push_back(8'd7);
    run_frame(1'b0, 1'b0, -1);

    // Ramp 0..15 with In1_SEND low every other cycle.
    pix.delete();
    for (int k = 0; k < 16; k++) pix.push_back(8'(k));
    run_frame(1'b1, 1'b0, -1);

    // Interleaved repeats to exercise forwarding: bin 3 = 8, bin 9 = 8.
    pix.delete();
    for (int r = 0; r < 2; r++) begin
      pix.push_back(8'd3); pix.push_back(8'd3); pix.push_back(8'd3); pix.push_back(8'd9);
      pix.push_back(8'd3); pix.push_back(8'd9); pix.push_back(8'd9); pix.push_back(8'd9);
    end
    run_frame(1'b0, 1'b0, -1);

    // Random pixels from a small set, random Out1_RDY during drain.
    pix.delete();
    for (int k = 0; k < 16; k++) pix.push_back(8'(40 + $urandom_range(0, 3)));
    run_frame(1'b0, 1'b1, -1);

    // Two frames of 255: the second must not see the first's counts.
    pix.delete();
    for (int k = 0; k < 16; k++) pix.push_back(8'd255);
    run_frame(1'b0, 1'b0, -1);
    run_frame(1'b0, 1'b1, -1);

    // Reset in the middle of a drain, then a frame of zeros.
    pix.delete();
    for (int k = 0; k < 16; k++) pix.push_back(8'($urandom));
    run_frame(1'b0, 1'b0, 101);
    reset_seq();
    pix.delete();
    for (int k = 0; k < 16; k++) pix.push_back(8'd0);
    run_frame(1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/histogram_bins.md
# histogram_bins

Downstream consumer of the pixel-forwarding stage in the histogram micro-benchmark. Accepts one 8-bit pixel token per cycle on the In1 channel and accumulates a 256-bin intensity histogram in a dual-port RAM. After FRAME_PIXELS tokens it drains the 256 bin counts, in order bin 0..255, on the Out1 channel. It zeroes each bin as it is sent, ready for the next frame.

## Interface
- FRAME_PIXELS, 262144: pixels per frame. Legal range 1 .. 2^COUNT_W-1.
- COUNT_W, 32: bin counter width, equal to the Out1_DATA width. No saturation logic, because the FRAME_PIXELS bound guarantees no overflow.
- CLK  in  1  single clock; all state on rising edge.
- RESET  in  1  synchronous, active-low reset.
- In1_DATA  in  8  pixel value, which is the bin index.
- In1_SEND  in  1  a token is available on In1.
- In1_COUNT  in  16  available-token count; ignored.
- In1_ACK  out  1  token consumed this cycle.
- Out1_DATA  out  COUNT_W  bin count.
- Out1_SEND  out  1  Out1_DATA valid and taken this cycle.
- Out1_RDY  in  1  downstream can accept a token this cycle.
- Out1_ACK  in  1  ignored.
- Out1_COUNT  out  16  constant 16'h1.

## Operation
- States: CLEAR, ACCUM, FLUSH, DRAIN.
- CLEAR
  - Entered on any cycle with RESET=0, from any state.
  - Writes 0 to addresses 0..255, one per cycle, for 256 cycles, then moves to ACCUM.
- ACCUM
  - In1_ACK = In1_SEND, combinational. A token is consumed exactly in the cycles where In1_ACK=1.
  - Stage 1: register the pixel p and issue a read of RAM[p].
  - Stage 2: write RAM[p] = read value + 1.
  - Forwarding: if the stage-1 address equals the stage-2 address, use the stage-2 result instead of the RAM read data. Back-to-back identical pixels must never lose a count.
  - A pixel counter increments on each ACK. On the FRAME_PIXELS-th ACK the counter clears and the state moves to FLUSH.
- FLUSH
  - Lasts 2 cycles while the pipeline writes retire.
  - In1_ACK=0.
- DRAIN
  - On entry, read bin 0. Read data is valid 1 cycle later.
  - Out1_SEND = (data valid) & Out1_RDY.
  - On each send, in the same cycle:
    - write 0 to the sent bin;
    - advance the pointer;
    - issue the read of the next bin.
  - This sustains one bin per cycle while Out1_RDY stays high.
  - Out1_RDY low holds Out1_DATA stable with Out1_SEND=0.
  - After bin 255 is sent, the next state is ACCUM. CLEAR is not needed because the bins are already zero.
- In1_ACK=0 in every state except ACCUM.
- Out1_SEND=0 in every state except DRAIN.
- In1 tokens arriving outside ACCUM stay pending and are not acknowledged.

## Timing
- Reset values, held from the cycle after RESET=0 is sampled:
  - In1_ACK=0, Out1_SEND=0, Out1_DATA=0, Out1_COUNT=16'h1;
  - pixel counter=0, drain pointer=0, state=CLEAR.
- Reset asserted mid-ACCUM, mid-FLUSH or mid-DRAIN:
  - the partial histogram is discarded;
  - the full 256-cycle CLEAR runs again.
- First In1_ACK is possible at cycle 256 after RESET is released.
- Final ACK of a frame at cycle t:
  - FLUSH at t+1 and t+2;
  - DRAIN entry at t+3;
  - earliest Out1_SEND at t+4.
- With Out1_RDY held high, the bins go out in 256 consecutive cycles, t+4..t+259, and ACCUM resumes at t+260.
- Accumulation throughput is 1 pixel per cycle with In1_SEND held high, including runs of identical pixels.
- Simultaneous events:
  - Out1_RDY falling in the cycle after a send: the next bin is held until Out1_RDY returns.
  - A new frame's In1 tokens during DRAIN: wait pending.

## Test plan
- FRAME_PIXELS=16, 16 tokens of value 7 with In1_SEND continuously high, Out1_RDY=1 → 256 sends: bin 7 = 16, all other bins 0; ACKs on 16 consecutive cycles.
- FRAME_PIXELS=16, ramp 0..15 with gaps (In1_SEND low on alternate cycles) → bins 0..15 = 1, bins 16..255 = 0; In1_ACK high only where In1_SEND is high.
- FRAME_PIXELS=8, pattern 3,3,3,9,3,9,9,9 back-to-back → bin 3 = 4, bin 9 = 4 (exercises forwarding).
- Out1_RDY pseudo-random at 50% during DRAIN → exactly 256 sends in bin order, no duplicates or drops, Out1_DATA stable while stalled.
- Two consecutive frames of 255s (FRAME_PIXELS=16) → second drain shows bin 255 = 16, not 32 (drain-zeroing verified).
- RESET pulsed low mid-DRAIN after bin 100 → no Out1_SEND and no In1_ACK for 256 cycles; next frame of 16 zeros → bin 0 = 16 only.
